rvfi_retire_packer: RTL and testbench

Producer side of the RVFI trace bus. It accepts one retired-instruction record per cycle from a core's writeback stage over a valid/ready handshake and buffers the records in a small FIFO. It then emits them in program order on up to NRET RVFI channels per cycle, assigning a monotonically increasing rvfi_order. It sits between core retirement logic and the formal checkers and bus monitors that consume RVFI.

---
 rtl/rvfi_pkg.sv | 25 ++
 rtl/rvfi_retire_fifo.sv | 67 ++++++
 rtl/rvfi_retire_packer.sv | 144 ++++++++++++++
 tb/tb_rvfi_retire_packer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_pkg.sv
// Shared types for the RVFI retire packer.
//   ORDER_W        width of the rvfi_order counter (wraps modulo 2^64)
//   rvfi_rec_t     one retired-instruction record at the default 32-bit sizing
//   packer_state_t RUN -> DRAIN (halt record queued) -> HALTED
package rvfi_pkg;

    localparam int ORDER_W   = 64;
    localparam int RVFI_ILEN = 32;
    localparam int RVFI_XLEN = 32;

    typedef struct packed {
        logic [RVFI_ILEN-1:0] insn;
        logic [RVFI_XLEN-1:0] pc_rdata;
        logic [RVFI_XLEN-1:0] pc_wdata;
        logic                 trap;
        logic                 halt;
    } rvfi_rec_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } packer_state_t;

endpackage

// File: rtl/rvfi_retire_fifo.sv
// Synchronous record FIFO with one push and a 0..NRET multi-pop per edge.
// The NRET oldest entries are visible combinationally on head[]; head[0] is
// the oldest. Entries beyond count are stale and must be ignored by the user.
//   clock, reset  clock and synchronous active-high reset (empties the FIFO)
//   push          write push_data at the tail this edge
//   pop_cnt       number of oldest entries to retire this edge (<= count)
//   count         current occupancy
//   head[NRET]    oldest NRET entries
module rvfi_retire_fifo
    import rvfi_pkg::*;
#(
    parameter type rec_t = rvfi_rec_t,
    parameter int  DEPTH = 4,
    parameter int  NRET  = 2,
    parameter int  CW    = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  rec_t          push_data,
    input  logic [CW-1:0] pop_cnt,
    output logic [CW-1:0] count,
    output rec_t          head [NRET]
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rec_t          mem_reg [DEPTH];
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;

    // Explicit modulo keeps the wrap correct even when DEPTH == 1.
    function automatic logic [AW-1:0] ptr_add(input logic [AW-1:0] p, input int n);
        return AW'((int'(p) + n) % DEPTH);
    endfunction

    // Storage carries no reset; only occupancy and pointers define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_add(wr_ptr_reg, 1);
            end
            rd_ptr_reg <= ptr_add(rd_ptr_reg, int'(pop_cnt));
            count_reg  <= count_reg + CW'(push) - pop_cnt;
        end
    end

    assign count = count_reg;

    generate
        for (genvar gi = 0; gi < NRET; gi++) begin : g_head
            assign head[gi] = mem_reg[ptr_add(rd_ptr_reg, gi)];
        end
    endgenerate

endmodule

// File: rtl/rvfi_retire_packer.sv
// Packs retired-instruction records into NRET RVFI channels per cycle.
// Records arrive one per cycle over in_valid/in_ready, are buffered in a
// FIFO, and leave in program order with a 64-bit wrapping rvfi_order.
//   clock, reset          clock and synchronous active-high reset
//   in_valid/in_ready     input handshake; in_ready is registered-state only
//   in_insn, in_pc_rdata, in_pc_wdata, in_trap, in_halt   record fields
//   out_stall             suppress all emission on this edge
//   rvfi_*                registered per-channel outputs, channel 0 = oldest
//   halted                set once the halt record has been emitted
module rvfi_retire_packer
    import rvfi_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int ILEN  = 32,
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ILEN-1:0]         in_insn,
    input  logic [XLEN-1:0]         in_pc_rdata,
    input  logic [XLEN-1:0]         in_pc_wdata,
    input  logic                    in_trap,
    input  logic                    in_halt,
    input  logic                    out_stall,
    output logic [NRET-1:0]         rvfi_valid,
    output logic [NRET*ORDER_W-1:0] rvfi_order,
    output logic [NRET*ILEN-1:0]    rvfi_insn,
    output logic [NRET*XLEN-1:0]    rvfi_pc_rdata,
    output logic [NRET*XLEN-1:0]    rvfi_pc_wdata,
    output logic [NRET-1:0]         rvfi_trap,
    output logic [NRET-1:0]         rvfi_halt,
    output logic                    halted
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ILEN-1:0] insn;
        logic [XLEN-1:0] pc_rdata;
        logic [XLEN-1:0] pc_wdata;
        logic            trap;
        logic            halt;
    } rec_t;

    packer_state_t      state_reg, state_next;
    logic [ORDER_W-1:0] order_ctr_reg, order_ctr_next;
    logic [CW-1:0]      count;
    logic [CW-1:0]      pop_cnt;
    logic               push;
    rec_t               push_data;
    rec_t               head [NRET];

    logic               valid_next [NRET];
    logic [ORDER_W-1:0] order_next [NRET];
    rec_t               rec_next   [NRET];
    logic [NRET-1:0]    halt_popped;

    // Depends only on registered occupancy, so a full FIFO never takes a
    // push on the same edge it pops.
    assign in_ready = !reset && (state_reg == RUN) && (count < CW'(DEPTH));
    assign push     = in_valid && in_ready;

    always_comb begin
        push_data          = '0;
        push_data.insn     = in_insn;
        push_data.pc_rdata = in_pc_rdata;
        push_data.pc_wdata = in_pc_wdata;
        push_data.trap     = in_trap;
        push_data.halt     = in_halt;
    end

    assign pop_cnt = out_stall ? '0 : ((count < CW'(NRET)) ? count : CW'(NRET));

    rvfi_retire_fifo #(
        .rec_t (rec_t),
        .DEPTH (DEPTH),
        .NRET  (NRET),
        .CW    (CW)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop_cnt   (pop_cnt),
        .count     (count),
        .head      (head)
    );

    // Channel i carries the i-th oldest entry when i < pop_cnt; otherwise zeros.
    generate
        for (genvar gi = 0; gi < NRET; gi++) begin : g_chan
            assign valid_next[gi]  = (CW'(gi) < pop_cnt);
            assign order_next[gi]  = valid_next[gi] ? order_ctr_reg + ORDER_W'(gi) : '0;
            assign rec_next[gi]    = valid_next[gi] ? head[gi] : '0;
            assign halt_popped[gi] = valid_next[gi] && head[gi].halt;
        end
    endgenerate

    assign order_ctr_next = order_ctr_reg + ORDER_W'(pop_cnt);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (push && in_halt) state_next = DRAIN;
            DRAIN:   if (|halt_popped)    state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= RUN;
            order_ctr_reg <= '0;
            rvfi_valid    <= '0;
            rvfi_order    <= '0;
            rvfi_insn     <= '0;
            rvfi_pc_rdata <= '0;
            rvfi_pc_wdata <= '0;
            rvfi_trap     <= '0;
            rvfi_halt     <= '0;
        end else begin
            state_reg     <= state_next;
            order_ctr_reg <= order_ctr_next;
            for (int i = 0; i < NRET; i++) begin
                rvfi_valid[i]                     <= valid_next[i];
                rvfi_order[i*ORDER_W +: ORDER_W]  <= order_next[i];
                rvfi_insn[i*ILEN +: ILEN]         <= rec_next[i].insn;
                rvfi_pc_rdata[i*XLEN +: XLEN]     <= rec_next[i].pc_rdata;
                rvfi_pc_wdata[i*XLEN +: XLEN]     <= rec_next[i].pc_wdata;
                rvfi_trap[i]                      <= rec_next[i].trap;
                rvfi_halt[i]                      <= rec_next[i].halt;
            end
        end
    end

    // The HALTED transition happens on the same edge the halt record is
    // registered onto its channel, so halted rises together with rvfi_halt.
    assign halted = (state_reg == HALTED);

endmodule

// File: tb/tb_rvfi_retire_packer.sv
module tb_rvfi_retire_packer;

    localparam int NRET  = 2;
    localparam int ILEN  = 32;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic                 clock;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [ILEN-1:0]      in_insn;
    logic [XLEN-1:0]      in_pc_rdata;
    logic [XLEN-1:0]      in_pc_wdata;
    logic                 in_trap;
    logic                 in_halt;
    logic                 out_stall;
    logic [NRET-1:0]      rvfi_valid;
    logic [NRET*64-1:0]   rvfi_order;
    logic [NRET*ILEN-1:0] rvfi_insn;
    logic [NRET*XLEN-1:0] rvfi_pc_rdata;
    logic [NRET*XLEN-1:0] rvfi_pc_wdata;
    logic [NRET-1:0]      rvfi_trap;
    logic [NRET-1:0]      rvfi_halt;
    logic                 halted;

    rvfi_retire_packer #(.NRET(NRET), .ILEN(ILEN), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_insn       (in_insn),
        .in_pc_rdata   (in_pc_rdata),
        .in_pc_wdata   (in_pc_wdata),
        .in_trap       (in_trap),
        .in_halt       (in_halt),
        .out_stall     (out_stall),
        .rvfi_valid    (rvfi_valid),
        .rvfi_order    (rvfi_order),
        .rvfi_insn     (rvfi_insn),
        .rvfi_pc_rdata (rvfi_pc_rdata),
        .rvfi_pc_wdata (rvfi_pc_wdata),
        .rvfi_trap     (rvfi_trap),
        .rvfi_halt     (rvfi_halt),
        .halted        (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic        trap;
        logic        halt;
    } rec_s;

    // Reference model: a queue of pending records in program order, the next
    // order number, whether records are still accepted, and whether the halt
    // record has gone out.
    rec_s            q[$];
    longint unsigned m_order;
    bit              m_accept;
    bit              m_halted;
    int              checks;
    int              errors;
    int              cyc;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic rec_s mk(input logic [31:0] insn, input logic h);
        rec_s r;
        r.insn     = insn;
        r.pc_rdata = 32'h0000_1000 + (insn << 2);
        r.pc_wdata = 32'h0000_1004 + (insn << 2);
        r.trap     = insn[4];
        r.halt     = h;
        return r;
    endfunction

    function automatic rec_s rnd(input logic h);
        rec_s r;
        r.insn     = $urandom;
        r.pc_rdata = $urandom;
        r.pc_wdata = $urandom;
        r.trap     = 1'($urandom_range(0, 1));
        r.halt     = h;
        return r;
    endfunction

    // One clock edge: drive inputs, check in_ready, advance the model, then
    // check every registered output one time unit after the edge.
    task automatic cycle(input bit rst, input bit v, input bit stall, input rec_s r);
        logic [NRET-1:0]      ev;
        logic [NRET*64-1:0]   eo;
        logic [NRET*32-1:0]   ei, epr, epw;
        logic [NRET-1:0]      et, eh;
        bit                   exp_rdy;
        int                   k;
        rec_s                 e;
        reset       = rst;
        in_valid    = v;
        in_insn     = r.insn;
        in_pc_rdata = r.pc_rdata;
        in_pc_wdata = r.pc_wdata;
        in_trap     = r.trap;
        in_halt     = r.halt;
        out_stall   = stall;
        #1;
        exp_rdy = !rst && m_accept && (q.size() < DEPTH);
        chk("in_ready", 128'(in_ready), 128'(exp_rdy));
        ev = '0; eo = '0; ei = '0; epr = '0; epw = '0; et = '0; eh = '0;
        if (rst) begin
            q.delete();
            m_order  = 0;
            m_accept = 1;
            m_halted = 0;
        end else begin
            k = stall ? 0 : ((q.size() < NRET) ? q.size() : NRET);
            for (int i = 0; i < k; i++) begin
                e = q.pop_front();
                ev[i]           = 1'b1;
                eo[i*64 +: 64]  = m_order + longint'(i);
                ei[i*32 +: 32]  = e.insn;
                epr[i*32 +: 32] = e.pc_rdata;
                epw[i*32 +: 32] = e.pc_wdata;
                et[i]           = e.trap;
                eh[i]           = e.halt;
                if (e.halt) m_halted = 1;
            end
            m_order += longint'(k);
            if (v && exp_rdy) begin
                q.push_back(r);
                if (r.halt) m_accept = 0;
            end
        end
        @(posedge clock);
        #1;
        chk("rvfi_valid",    128'(rvfi_valid),    128'(ev));
        chk("rvfi_order",    128'(rvfi_order),    128'(eo));
        chk("rvfi_insn",     128'(rvfi_insn),     128'(ei));
        chk("rvfi_pc_rdata", 128'(rvfi_pc_rdata), 128'(epr));
        chk("rvfi_pc_wdata", 128'(rvfi_pc_wdata), 128'(epw));
        chk("rvfi_trap",     128'(rvfi_trap),     128'(et));
        chk("rvfi_halt",     128'(rvfi_halt),     128'(eh));
        chk("halted",        128'(halted),        128'(m_halted));
        $display("cyc %0d rst=%0b v=%0b stall=%0b rdy=%0b valid=%b order0=%0h order1=%0h halted=%0b q=%0d",
                 cyc, rst, v, stall, exp_rdy, rvfi_valid, rvfi_order[63:0], rvfi_order[127:64],
                 halted, q.size());
        cyc++;
    endtask

    initial begin
        rec_s idle;
        bit   rst, v, stall, h;
        idle = mk(32'h0, 1'b0);
        checks = 0; errors = 0; cyc = 0;
        m_order = 0; m_accept = 1; m_halted = 0;
        reset = 1'b1; in_valid = 1'b0; in_insn = '0; in_pc_rdata = '0;
        in_pc_wdata = '0; in_trap = 1'b0; in_halt = 1'b0; out_stall = 1'b0;

        // Reset, then three back-to-back records, each emitted alone on channel 0.
        cycle(1, 0, 0, idle);
        cycle(1, 0, 0, idle);
        cycle(0, 1, 0, mk(32'h13, 0));
        cycle(0, 1, 0, mk(32'h93, 0));
        cycle(0, 1, 0, mk(32'h113, 0));
        cycle(0, 0, 0, idle);
        cycle(0, 0, 0, idle);

        // Fill under stall until in_ready drops, then drain two at a time.
        cycle(1, 0, 0, idle);
        for (int i = 0; i < 4; i++) cycle(0, 1, 1, mk(32'h200 + i, 0));
        cycle(0, 1, 1, mk(32'h2FF, 0));
        cycle(0, 0, 0, idle);
        cycle(0, 0, 0, idle);
        cycle(0, 0, 0, idle);

        // Halt record behind two queued entries.
        cycle(0, 1, 1, mk(32'h300, 0));
        cycle(0, 1, 1, mk(32'h301, 0));
        cycle(0, 1, 1, mk(32'h302, 1));
        cycle(0, 1, 1, mk(32'h303, 0));
        cycle(0, 1, 0, mk(32'h304, 0));
        cycle(0, 1, 0, mk(32'h305, 0));
        cycle(0, 0, 0, idle);
        cycle(0, 0, 0, idle);

        // Reset with three entries queued, stall released on the reset edge.
        cycle(1, 0, 0, idle);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, mk(32'h400 + i, 0));
        cycle(1, 0, 0, idle);
        cycle(0, 1, 0, mk(32'h410, 0));
        cycle(0, 0, 0, idle);

        // Order counter wrap from 2^64-1 to 0.
        force dut.order_ctr_reg = 64'hFFFF_FFFF_FFFF_FFFF;
        m_order = 64'hFFFF_FFFF_FFFF_FFFF;
        cycle(0, 0, 1, idle);
        release dut.order_ctr_reg;
        cycle(0, 1, 1, mk(32'h500, 0));
        cycle(0, 1, 1, mk(32'h501, 0));
        cycle(0, 0, 0, idle);
        cycle(0, 0, 0, idle);

        // Push on the same edge as a two-entry pop.
        cycle(0, 1, 1, mk(32'h600, 0));
        cycle(0, 1, 1, mk(32'h601, 0));
        cycle(0, 1, 0, mk(32'h602, 0));
        cycle(0, 0, 0, idle);
        cycle(0, 0, 0, idle);

        // Randomized traffic with occasional halts and resets.
        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(0, 59) == 0) || (m_halted && $urandom_range(0, 7) == 0);
            v     = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 3) == 0);
            h     = ($urandom_range(0, 29) == 0);
            cycle(rst, v, stall, rnd(h));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
